light_pattern_monitor: RTL and testbench

- Receive-side checker for the 8-segment green/red light bar.
- Samples the greenLight/redLight bus produced by the pattern generator and decodes the displayed step (0..3).
- Debounces transitions, locks onto the 0→1→2→3→0 sequence and flags out-of-order, illegal or stalled patterns.
- Sits beside the light bar driver as a self-test/diagnostic block; its outputs go to status LEDs and the fault logger.

---
 rtl/light_pattern_monitor.sv | 194 +++++++++++++++++++
 tb/tb_light_pattern_monitor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/light_pattern_monitor.sv
// light_pattern_monitor: receive-side checker for the 8-segment green/red light bar.
// Registers the bar, decodes the displayed step, debounces it, locks onto the
// 0->1->2->3->0 sequence and flags out-of-order, illegal or stalled patterns.
// Optional feature macro: LIGHT_MONITOR_STICKY_ERR_EN adds clearError/errorSticky.
module light_pattern_monitor #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned LOCK_STEPS     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 37500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [0:7] greenLight,
  input  logic [0:7] redLight,
`ifdef LIGHT_MONITOR_STICKY_ERR_EN
  input  logic       clearError,
  output logic       errorSticky,
`endif
  output logic [1:0] patternId,
  output logic       patternValid,
  output logic       locked,
  output logic       stepPulse,
  output logic       errorPulse,
  output logic [7:0] errorCount
);

  localparam logic [2:0]  INV     = 3'd4;
  localparam logic [7:0]  STABLE  = 8'(STABLE_CYCLES);
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_STEPS);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  logic [0:7]  r_green, r_red;
  logic [2:0]  r_prevDec, r_lastAcc;
  logic [7:0]  r_stableCnt;
  logic [3:0]  r_lockCnt;
  logic [31:0] r_toCnt;
  logic [1:0]  r_patternId;
  logic        r_patternValid, r_stepPulse, r_errPulse;
  logic [7:0]  r_errCnt;
  state_t      r_state, w_next;

  logic [2:0]  w_dec;
  logic        w_diff, w_acc, w_accValid, w_accInv, w_succ, w_toExp;
  logic        w_step, w_err;
  logic [7:0]  w_cntNext;
  logic [1:0]  w_code, w_nextId;
  logic [3:0]  w_lockInc, w_lockCntNext;

  // Input stage: sample the bar once so decode works on a stable value
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_green <= '0;
      r_red   <= '0;
    end else begin
      r_green <= greenLight;
      r_red   <= redLight;
    end
  end

  // Decode the registered pair into a step code, or INVALID for anything else
  always_comb begin
    w_dec = INV;
    case ({r_green, r_red})
      16'b11110000_00001111: w_dec = 3'd0;
      16'b00001111_11110000: w_dec = 3'd1;
      16'b00111100_11000011: w_dec = 3'd2;
      16'b11000011_00111100: w_dec = 3'd3;
      default:               w_dec = INV;
    endcase
  end

  assign w_diff     = (w_dec != r_prevDec);
  assign w_cntNext  = w_diff ? 8'd1 : ((r_stableCnt >= STABLE) ? STABLE : r_stableCnt + 8'd1);
  // Accept only when the run first reaches the threshold and shows something new
  assign w_acc      = (w_cntNext == STABLE) && (w_diff || (r_stableCnt < STABLE)) &&
                      (w_dec != r_lastAcc);
  assign w_accValid = w_acc && !w_dec[2];
  assign w_accInv   = w_acc &&  w_dec[2];
  assign w_code     = w_dec[1:0];
  assign w_nextId   = r_patternId + 2'd1;
  assign w_succ     = (w_code == w_nextId);
  assign w_lockInc  = r_lockCnt + 4'd1;
  // An accept event in the same cycle overrides the stall timer
  assign w_toExp    = (r_state == LOCKED) && !w_acc && (r_toCnt == TO_LAST);

  // Stability filter: run-length of identical decodes and last accepted value
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prevDec   <= INV;
      r_stableCnt <= '0;
      r_lastAcc   <= INV;
    end else begin
      r_prevDec   <= w_dec;
      r_stableCnt <= w_cntNext;
      if (w_acc) r_lastAcc <= w_dec;
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= SEARCH;
    else        r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      SEARCH: if (w_accValid) w_next = TRACK;
      TRACK: begin
        if (w_accInv)                                       w_next = SEARCH;
        else if (w_accValid && w_succ && w_lockInc == LOCK_N) w_next = LOCKED;
      end
      LOCKED: begin
        if (w_accInv)                    w_next = SEARCH;
        else if (w_accValid && !w_succ)  w_next = TRACK;
        else if (w_toExp)                w_next = TRACK;
      end
      default: w_next = SEARCH;
    endcase
  end

  // FSM output logic: pulses and lock-progress counter per state
  always_comb begin
    w_step        = 1'b0;
    w_err         = 1'b0;
    w_lockCntNext = r_lockCnt;
    case (r_state)
      SEARCH: if (w_accValid) w_lockCntNext = '0;
      TRACK:  if (w_accValid) w_lockCntNext = w_succ ? w_lockInc : 4'd0;
      LOCKED: begin
        if (w_accValid) begin
          if (w_succ) w_step = 1'b1;
          else begin
            w_err         = 1'b1;
            w_lockCntNext = '0;
          end
        end else if (w_accInv) begin
          w_err = 1'b1;
        end else if (w_toExp) begin
          w_err         = 1'b1;
          w_lockCntNext = '0;
        end
      end
      default: w_lockCntNext = '0;
    endcase
  end

  // Datapath: displayed code, pulses, saturating fault count, stall timer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_patternId    <= '0;
      r_patternValid <= 1'b0;
      r_stepPulse    <= 1'b0;
      r_errPulse     <= 1'b0;
      r_errCnt       <= '0;
      r_lockCnt      <= '0;
      r_toCnt        <= '0;
    end else begin
      if (w_accValid) begin
        r_patternId    <= w_code;
        r_patternValid <= 1'b1;
      end else if (w_accInv) begin
        r_patternValid <= 1'b0;
      end
      r_stepPulse <= w_step;
      r_errPulse  <= w_err;
      if (w_err && r_errCnt != 8'hFF) r_errCnt <= r_errCnt + 8'd1;
      r_lockCnt <= w_lockCntNext;
      if (r_state != LOCKED || w_acc || w_toExp) r_toCnt <= '0;
      else                                       r_toCnt <= r_toCnt + 32'd1;
    end
  end

`ifdef LIGHT_MONITOR_STICKY_ERR_EN
  logic r_sticky;
  // Sticky fault flag: a fault pulse beats a simultaneous clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          r_sticky <= 1'b0;
    else if (r_errPulse) r_sticky <= 1'b1;
    else if (clearError) r_sticky <= 1'b0;
  end
  assign errorSticky = r_sticky;
`endif

  assign patternId    = r_patternId;
  assign patternValid = r_patternValid;
  assign locked       = (r_state == LOCKED);
  assign stepPulse    = r_stepPulse;
  assign errorPulse   = r_errPulse;
  assign errorCount   = r_errCnt;

endmodule

// File: tb/tb_light_pattern_monitor.sv
// tb_light_pattern_monitor: directed test-plan phases plus random code streams,
// every cycle compared against a sample-history reference model.
module tb_light_pattern_monitor;
  localparam int ST = 4, LK = 2, TO = 100;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [0:7] greenLight = '0, redLight = '0;
  logic       clearError = 1'b0;
  logic [1:0] patternId;
  logic       patternValid, locked, stepPulse, errorPulse;
  logic [7:0] errorCount;
  logic       errorSticky;

  light_pattern_monitor #(.STABLE_CYCLES(ST), .LOCK_STEPS(LK), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .greenLight(greenLight), .redLight(redLight),
`ifdef LIGHT_MONITOR_STICKY_ERR_EN
    .clearError(clearError), .errorSticky(errorSticky),
`endif
    .patternId(patternId), .patternValid(patternValid), .locked(locked),
    .stepPulse(stepPulse), .errorPulse(errorPulse), .errorCount(errorCount)
  );

`ifndef LIGHT_MONITOR_STICKY_ERR_EN
  assign errorSticky = 1'b0;
`endif

  always #5 clock = ~clock;

  logic [0:7] G_TAB [4] = '{8'b11110000, 8'b00001111, 8'b00111100, 8'b11000011};
  logic [0:7] IG    [4] = '{8'b00000000, 8'b11111111, 8'b11111111, 8'b11110000};
  logic [0:7] IR    [4] = '{8'b00000000, 8'b00000000, 8'b11111111, 8'b11110000};

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: SEARCH is "not valid", LOCKED is "locked", else tracking
  int m_pid, m_valid, m_locked, m_streak, m_since, m_cnt, m_step, m_err, m_sticky;
  int m_run, m_runVal, m_last;
  logic [0:7] m_pg, m_pr;

  function automatic int decode(input logic [0:7] g, input logic [0:7] r);
    for (int i = 0; i < 4; i++)
      if (g == G_TAB[i] && r == ~G_TAB[i]) return i;
    return 4;
  endfunction

  task automatic model_reset();
    m_pid = 0; m_valid = 0; m_locked = 0; m_streak = 0; m_since = 0; m_cnt = 0;
    m_step = 0; m_err = 0; m_sticky = 0; m_run = 0; m_runVal = 4; m_last = 4;
    m_pg = '0; m_pr = '0;
  endtask

  task automatic fault();
    m_err = 1;
    if (m_cnt < 255) m_cnt++;
  endtask

  // One rising edge: the decision uses the sample captured at the previous edge
  task automatic model_step();
    int d;
    bit evt;
    if (m_err) m_sticky = 1;
    else if (clearError) m_sticky = 0;
    m_step = 0; m_err = 0;
    d = decode(m_pg, m_pr);
    if (d == m_runVal) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_run = 1; m_runVal = d;
    end
    evt = (m_run == ST) && (d != m_last);
    if (evt) begin
      m_last  = d;
      m_since = 0;
      if (d == 4) begin
        if (m_locked) fault();
        m_valid = 0; m_locked = 0;
      end else if (!m_valid) begin
        m_pid = d; m_valid = 1; m_streak = 0;
      end else if (!m_locked) begin
        if (d == (m_pid + 1) % 4) begin
          m_streak++;
          if (m_streak == LK) m_locked = 1;
        end else m_streak = 0;
        m_pid = d;
      end else begin
        if (d == (m_pid + 1) % 4) m_step = 1;
        else begin
          fault(); m_locked = 0; m_streak = 0;
        end
        m_pid = d;
      end
    end else if (m_locked) begin
      m_since++;
      if (m_since == TO) begin
        fault(); m_locked = 0; m_streak = 0; m_since = 0;
      end
    end
    m_pg = greenLight; m_pr = redLight;
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
    chk("patternId", 32'(patternId), 32'(m_pid));
    chk("patternValid", 32'(patternValid), 32'(m_valid));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("stepPulse", 32'(stepPulse), 32'(m_step));
    chk("errorPulse", 32'(errorPulse), 32'(m_err));
    chk("errorCount", 32'(errorCount), 32'(m_cnt));
`ifdef LIGHT_MONITOR_STICKY_ERR_EN
    chk("errorSticky", 32'(errorSticky), 32'(m_sticky));
`endif
  endtask

  // Hold a code (4 = some illegal pair) for n clocks
  task automatic hold(input int code, input int n);
    int k;
    if (code < 4) begin
      greenLight = G_TAB[code];
      redLight   = ~G_TAB[code];
    end else begin
      k = $urandom_range(0, 3);
      greenLight = IG[k];
      redLight   = IR[k];
    end
    repeat (n) begin
`ifdef LIGHT_MONITOR_STICKY_ERR_EN
      clearError = ($urandom_range(0, 15) == 0);
`endif
      cyc();
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pid"}, 32'(patternId), 0);
    chk({tag, "_valid"}, 32'(patternValid), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_step"}, 32'(stepPulse), 0);
    chk({tag, "_errp"}, 32'(errorPulse), 0);
    chk({tag, "_errcnt"}, 32'(errorCount), 0);
    chk({tag, "_sticky"}, 32'(errorSticky), 0);
  endtask

  initial begin
    int code, len, r;
    model_reset();
    #12 check_zero("rst");
    #1 reset = 1'b1;

    // 1: first code acquired, no lock
    hold(0, 10);
    chk("t1_valid", 32'(patternValid), 1);
    chk("t1_locked", 32'(locked), 0);
    // 2: lock on code 2, then steps 3 and 0
    hold(1, 20); hold(2, 20);
    chk("t2_locked", 32'(locked), 1);
    hold(3, 20); hold(0, 20); hold(1, 20); hold(2, 20); hold(3, 20);
    // 3: out-of-order code while locked on 3
    hold(1, 20);
    chk("t3_errcnt", 32'(errorCount), 1);
    chk("t3_pid", 32'(patternId), 1);
    // 4: short glitch is filtered; a held illegal pair drops to SEARCH
    hold(2, 20); hold(3, 20);
    greenLight = 8'hFF; redLight = 8'h00;
    repeat (3) cyc();
    hold(3, 10);
    chk("t4_glitch_cnt", 32'(errorCount), 1);
    greenLight = 8'hFF; redLight = 8'h00;
    repeat (10) cyc();
    chk("t4_valid", 32'(patternValid), 0);
    chk("t4_errcnt", 32'(errorCount), 2);
    // 5: stall timeout, then a successor gives no pulse
    hold(0, 10); hold(1, 10); hold(2, 110);
    chk("t5_locked", 32'(locked), 0);
    chk("t5_pid", 32'(patternId), 2);
    hold(3, 10);

    // Random streams biased toward correct successors
    for (int s = 0; s < 400; s++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      code = (m_pid + 1) % 4;
      else if (r < 80) code = $urandom_range(0, 3);
      else             code = 4;
      len = ($urandom_range(0, 19) == 0) ? $urandom_range(90, 130) : $urandom_range(1, 12);
      hold(code, len);
    end

    // 6: drive repeated lock/break cycles past counter saturation
    for (int s = 0; s < 280; s++) begin
      hold(0, 5); hold(1, 5); hold(2, 5);
    end
    chk("t6_sat", 32'(errorCount), 255);
    hold(0, 2);
    #2 reset = 1'b0;
    #1 check_zero("midrst");
    model_reset();
    #2 reset = 1'b1;
    hold(0, 10);
    chk("t6_after_valid", 32'(patternValid), 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
